// File: rtl/pcm_pkg.sv
// pcm_pkg -- shared types and constants for the PCM sample-to-byte-FIFO writer.
// Build option: define PCM_SYNC_HEADER_EN to add a HEADER state that emits
// SYNC_BYTE ahead of every packet. Without it the state type has no HEADER.
package pcm_pkg;

`ifdef PCM_SYNC_HEADER_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_HEADER = 2'd2
  } pcm_state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } pcm_state_t;
`endif

  // Marker byte that leads each packet when the header option is built in.
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Number of bytes a sample is split into (width is a multiple of 8).
  function automatic int bytes_per_sample(input int sample_width);
    return sample_width / 8;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter -- up counter that sticks at all-ones instead of wrapping.
// clear has priority over inc; reset is asynchronous active-low.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  // Count up on inc, hold once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pcm_fifo_writer.sv
// pcm_fifo_writer -- latches a PCM sample and writes it into a byte FIFO, one
// byte per non-full cycle, in LSB-first or MSB-first order.
// Build option: PCM_SYNC_HEADER_EN prefixes every packet with SYNC_BYTE.
// Samples arriving mid-packet are dropped and counted, except on the cycle of
// the final byte write, where a new sample starts the next packet directly.
module pcm_fifo_writer
  import pcm_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int LSB_FIRST    = 1,
  parameter int DROP_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    sample_valid_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                    fifo_full_i,
  output logic                    fifo_wr_en_o,
  output logic [7:0]              fifo_data_o,
  output logic                    busy_o,
  output logic [DROP_W-1:0]       drop_count_o
);

  localparam int BYTES = bytes_per_sample(SAMPLE_WIDTH);
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

`ifdef PCM_SYNC_HEADER_EN
  localparam pcm_state_t START_STATE = ST_HEADER;
`else
  localparam pcm_state_t START_STATE = ST_SEND;
`endif

  pcm_state_t              state_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [SAMPLE_WIDTH-1:0] sample_reg;

  logic       wr_en;
  logic       final_write;
  logic       accept_idle;
  logic       accept_b2b;
  logic       drop_pulse;
  logic [7:0] byte_sel [BYTES];

  // Byte view of the latched sample in transmit order: slot 0 goes out first.
  for (genvar gi = 0; gi < BYTES; gi++) begin : g_byte_order
    if (LSB_FIRST != 0) begin : g_lsb
      assign byte_sel[gi] = sample_reg[8*gi +: 8];
    end else begin : g_msb
      assign byte_sel[gi] = sample_reg[8*(BYTES-1-gi) +: 8];
    end
  end

  // A write happens on every non-idle cycle the FIFO can take it, so a full
  // FIFO freezes state, index and data without any extra bookkeeping.
  assign wr_en        = (state_reg != ST_IDLE) && !fifo_full_i;
  assign final_write  = (state_reg == ST_SEND) && wr_en && (idx_reg == LAST_IDX);
  assign accept_idle  = (state_reg == ST_IDLE) && sample_valid_i && enable_i;
  assign accept_b2b   = final_write && sample_valid_i && enable_i;
  assign drop_pulse   = (state_reg != ST_IDLE) && sample_valid_i && !accept_b2b;

  assign fifo_wr_en_o = wr_en;
  assign busy_o       = (state_reg != ST_IDLE);

  // Output byte is a pure decode of registered state so it holds while stalled.
  always_comb begin
    fifo_data_o = 8'h00;
    case (state_reg)
      ST_SEND:   fifo_data_o = byte_sel[idx_reg];
`ifdef PCM_SYNC_HEADER_EN
      ST_HEADER: fifo_data_o = SYNC_BYTE;
`endif
      default:   fifo_data_o = 8'h00;
    endcase
  end

  // Packet sequencer: accept in IDLE, step one byte per write, chain a new
  // sample on the final write when one is offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      idx_reg    <= '0;
      sample_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept_idle) begin
            sample_reg <= sample_i;
            idx_reg    <= '0;
            state_reg  <= START_STATE;
          end
        end
`ifdef PCM_SYNC_HEADER_EN
        ST_HEADER: begin
          if (wr_en) begin
            state_reg <= ST_SEND;
          end
        end
`endif
        ST_SEND: begin
          if (wr_en) begin
            if (idx_reg == LAST_IDX) begin
              idx_reg <= '0;
              if (accept_b2b) begin
                sample_reg <= sample_i;
                state_reg  <= START_STATE;
              end else begin
                state_reg <= ST_IDLE;
              end
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          idx_reg   <= '0;
        end
      endcase
    end
  end

  // Rejected samples are tallied; the count never wraps.
  sat_counter #(
    .WIDTH(DROP_W)
  ) u_drop_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (drop_pulse),
    .clear(1'b0),
    .count(drop_count_o)
  );

endmodule

// File: tb/tb_pcm_fifo_writer.sv
// tb_pcm_fifo_writer -- scoreboard bench for pcm_fifo_writer.
// Two instances share stimulus: dut_a is LSB-first with a 4-bit drop counter,
// dut_b is MSB-first with a 16-bit drop counter. Expected bytes and the cycle
// each must appear in are queued by the stimulus; monitors pop and compare.
// Honors PCM_SYNC_HEADER_EN so either build can be checked.
module tb_pcm_fifo_writer;

  localparam int SW    = 24;
  localparam int BYTES = SW / 8;
`ifdef PCM_SYNC_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          valid;
  logic [SW-1:0] sample;
  logic          full;

  logic          wr_a, wr_b;
  logic [7:0]    data_a, data_b;
  logic          busy_a, busy_b;
  logic [3:0]    drop_a;
  logic [15:0]   drop_b;

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   drops   = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  pcm_fifo_writer #(.SAMPLE_WIDTH(SW), .LSB_FIRST(1), .DROP_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .sample_valid_i(valid),
    .sample_i(sample), .fifo_full_i(full), .fifo_wr_en_o(wr_a),
    .fifo_data_o(data_a), .busy_o(busy_a), .drop_count_o(drop_a)
  );

  pcm_fifo_writer #(.SAMPLE_WIDTH(SW), .LSB_FIRST(0), .DROP_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .sample_valid_i(valid),
    .sample_i(sample), .fifo_full_i(full), .fifo_wr_en_o(wr_b),
    .fifo_data_o(data_b), .busy_o(busy_b), .drop_count_o(drop_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_of(input logic [SW-1:0] s, input int k, input bit lsb);
    return lsb ? s[8*k +: 8] : s[8*(BYTES-1-k) +: 8];
  endfunction

  task automatic push_byte(input logic [7:0] da, input logic [7:0] db, input int c);
    exp_t e;
    e.data = da; e.cyc = c; q_a.push_back(e);
    e.data = db; e.cyc = c; q_b.push_back(e);
  endtask

  // Full packet with no stalls, first write at cycle 'first'.
  task automatic push_pkt(input logic [SW-1:0] s, input int first);
    if (H != 0) push_byte(8'hA5, 8'hA5, first);
    for (int k = 0; k < BYTES; k++)
      push_byte(byte_of(s, k, 1'b1), byte_of(s, k, 1'b0), first + H + k);
  endtask

  // Offer a sample this cycle and queue its packet.
  task automatic start_pkt(input logic [SW-1:0] s);
    sample = s;
    valid  = 1'b1;
    push_pkt(s, cyc + 1);
  endtask

  // Monitor for dut_a.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (wr_a === 1'b1) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_extra_write actual=0x%0h required=no write (cycle %0d)", data_a, cyc);
      end else begin
        e = q_a.pop_front();
        $display("[TB] a write 0x%02h at cycle %0d (expected 0x%02h at %0d)", data_a, cyc, e.data, e.cyc);
        chk("a_byte", {24'h0, data_a}, {24'h0, e.data});
        chk("a_byte_cycle", cyc, e.cyc);
      end
    end
  end

  // Monitor for dut_b.
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (wr_b === 1'b1) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_extra_write actual=0x%0h required=no write (cycle %0d)", data_b, cyc);
      end else begin
        e = q_b.pop_front();
        $display("[TB] b write 0x%02h at cycle %0d (expected 0x%02h at %0d)", data_b, cyc, e.data, e.cyc);
        chk("b_byte", {24'h0, data_b}, {24'h0, e.data});
        chk("b_byte_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n, b0, f;
    logic [SW-1:0] s;
    rst_n = 1'b0; enable = 1'b0; valid = 1'b0; sample = '0; full = 1'b0;

    // Reset values.
    tick;
    @(negedge clk);
    chk("rst_wr_en_a", {31'h0, wr_a}, 32'h0);
    chk("rst_data_a", {24'h0, data_a}, 32'h0);
    chk("rst_busy_a", {31'h0, busy_a}, 32'h0);
    chk("rst_drop_a", {28'h0, drop_a}, 32'h0);
    chk("rst_wr_en_b", {31'h0, wr_b}, 32'h0);
    chk("rst_data_b", {24'h0, data_b}, 32'h0);
    tick;

    // Basic packet, offered on the first edge after reset release.
    rst_n = 1'b1; enable = 1'b1;
    start_pkt(24'h123456);
    tick; valid = 1'b0;
    for (int i = 0; i <= BYTES + H; i++) begin
      @(negedge clk);
      chk("busy_a", {31'h0, busy_a}, {31'h0, (i < BYTES + H)});
      chk("busy_b", {31'h0, busy_b}, {31'h0, (i < BYTES + H)});
      tick;
    end

    // FIFO full for two cycles right after byte 0.
    n = cyc; s = 24'h654321;
    sample = s; valid = 1'b1;
    b0 = n + 1 + H;
    if (H != 0) push_byte(8'hA5, 8'hA5, n + 1);
    push_byte(8'h21, 8'h65, b0);
    push_byte(8'h43, 8'h43, b0 + 3);
    push_byte(8'h65, 8'h21, b0 + 4);
    tick; valid = 1'b0;
    while (cyc < b0 + 1) tick;
    full = 1'b1;
    @(negedge clk);
    chk("stall_wr_en_a", {31'h0, wr_a}, 32'h0);
    chk("stall_data_a", {24'h0, data_a}, 32'h43);
    chk("stall_data_b", {24'h0, data_b}, 32'h43);
    tick;
    @(negedge clk);
    chk("stall2_wr_en_b", {31'h0, wr_b}, 32'h0);
    chk("stall2_busy_a", {31'h0, busy_a}, 32'h1);
    tick; full = 1'b0;
    repeat (3) tick;

    // Second sample one cycle after the first is dropped.
    start_pkt(24'h0A0B0C);
    tick; sample = 24'hFFFFFF; valid = 1'b1;
    tick; valid = 1'b0; drops = drops + 1;
    repeat (BYTES + H) tick;
    @(negedge clk);
    chk("drop_once_a", {28'h0, drop_a}, drops);
    chk("drop_once_b", {16'h0, drop_b}, drops);
    tick;

    // Back-to-back on the final byte; enable low mid-packet does not abort.
    n = cyc;
    start_pkt(24'h332211);
    tick; valid = 1'b0; enable = 1'b0;
    f = n + H + BYTES;
    while (cyc < f) tick;
    enable = 1'b1;
    start_pkt(24'hABCDEF);
    tick; valid = 1'b0;
    repeat (BYTES + H + 1) tick;
    @(negedge clk);
    chk("b2b_drop_a", {28'h0, drop_a}, drops);
    chk("b2b_busy_a", {31'h0, busy_a}, 32'h0);
    tick;

    // Valid while disabled in IDLE: ignored, not counted.
    enable = 1'b0; sample = 24'h777777; valid = 1'b1;
    tick; valid = 1'b0; enable = 1'b1;
    @(negedge clk);
    chk("ign_busy_a", {31'h0, busy_a}, 32'h0);
    chk("ign_drop_b", {16'h0, drop_b}, drops);
    tick;
    repeat (2) tick;

    // Drop saturation: every non-idle cycle of each packet drops a sample.
    for (int p = 0; p < 6; p++) begin
      enable = 1'b1;
      start_pkt({8'(p + 1), 8'hC3, 8'h5A});
      tick; enable = 1'b0;
      repeat (BYTES + H) tick;
      valid = 1'b0; enable = 1'b1;
      drops = drops + BYTES + H;
      @(negedge clk);
      chk("sat_drop_a", {28'h0, drop_a}, (drops > 15) ? 15 : drops);
      chk("sat_drop_b", {16'h0, drop_b}, drops);
      tick;
    end

    // Reset after byte 1: rest of the packet is discarded.
    n = cyc; s = 24'h5B6C7D;
    sample = s; valid = 1'b1;
    if (H != 0) push_byte(8'hA5, 8'hA5, n + 1);
    push_byte(8'h7D, 8'h5B, n + 1 + H);
    push_byte(8'h6C, 8'h6C, n + 2 + H);
    tick; valid = 1'b0;
    while (cyc < n + 2 + H) tick;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en_a", {31'h0, wr_a}, 32'h0);
    chk("mid_rst_busy_a", {31'h0, busy_a}, 32'h0);
    chk("mid_rst_data_b", {24'h0, data_b}, 32'h0);
    chk("mid_rst_drop_b", {16'h0, drop_b}, 32'h0);
    drops = 0;
    tick; tick;
    rst_n = 1'b1;
    repeat (6) tick;
    @(negedge clk);
    chk("post_rst_busy_b", {31'h0, busy_b}, 32'h0);
    tick;

    chk("pending_a", q_a.size(), 32'h0);
    chk("pending_b", q_b.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
